// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the RV32I pipeline memory stage.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package pipeline_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The access size sits in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == 2'b01) && a[0]) || ((size == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane formatting for stores and lane extraction/extension for loads.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller gates the results with its own request.
// Ports: funct3_i/addr_lo_i select size and lane, store_data_i is the raw
//        store operand, rdata_i is the bus word (already zeroed on timeout);
//        be_o/wdata_o drive the bus, load_data_o is the extended load value,
//        mis_o flags an access that is not naturally aligned.
module load_store_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        mis_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign mis_o = is_misaligned(funct3_i[1:0], addr_lo_i);

    // Store data is replicated across every lane so the memory only has to
    // honour the byte enables.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = store_data_i;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
    end

    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        load_data_o = 32'h0;
        case (funct3_i)
            F3_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: load_data_o = {24'h0, byte_sel};
            F3_H:  load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU: load_data_o = {16'h0, half_sel};
            F3_W:  load_data_o = rdata_i;
            default: load_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: req/ack data bus access, timeout, stall and M/W register.
// Latency: 1 cycle into W; +N stall cycles until ack, at most TIMEOUT.
// Backpressure: MemStall holds upstream and inserts W bubbles until done.
// Ports: *M inputs are the EM register; dmem_* is the data bus (dmem_req is
//        combinational, completed by dmem_ack); *W outputs are the registered
//        M/W fields; MemStall goes to the hazard unit; BusErr is a sticky
//        timeout flag cleared only by rst.
// TIMEOUT must be >= 1 and fit in CNT_W bits (2**CNT_W > TIMEOUT).
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUoutM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] Rd2M,
    input  logic [31:0] inc_PCM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        MemStall,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUoutW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] inc_PCW,
    output logic        MisalignW,
    output logic        BusErr
);

    mem_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             buserr_q;

    logic        mem_op;
    logic        mis_raw;
    logic        mis;
    logic        timeout_hit;
    logic        done;
    logic [3:0]  be_raw;
    logic [31:0] rdata_eff;
    logic [31:0] load_data;

    logic        regwrite_q;
    logic [1:0]  resultsrc_q;
    logic [31:0] aluout_q;
    logic [31:0] readdata_q;
    logic [4:0]  rd_q;
    logic [31:0] incpc_q;
    logic        misalign_q;

    assign mem_op = MemWriteM | (ResultSrcM == RES_MEM);
    assign mis    = mem_op & mis_raw;

    // Misaligned accesses are dropped here and never reach the bus.
    assign dmem_req   = mem_op & ~mis & ~rst;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = {ALUoutM[31:2], 2'b00};
    assign dmem_be    = dmem_req ? be_raw : 4'b0000;

    // An ack in the final wait cycle wins over the timeout.
    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT)) && !dmem_ack;
    assign done        = dmem_ack | timeout_hit;
    assign MemStall    = dmem_req & ~done;

    // A timed-out load completes with a zero word.
    assign rdata_eff = timeout_hit ? 32'h0 : dmem_rdata;

    load_store_align u_align (
        .funct3_i     (funct3M),
        .addr_lo_i    (ALUoutM[1:0]),
        .store_data_i (Rd2M),
        .rdata_i      (rdata_eff),
        .be_o         (be_raw),
        .wdata_o      (dmem_wdata),
        .load_data_o  (load_data),
        .mis_o        (mis_raw)
    );

    // Bus handshake FSM; cnt_q counts cycles spent in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dmem_req && !dmem_ack) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        buserr_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // M/W register: a stall injects a bubble but keeps the data fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            aluout_q    <= 32'h0;
            readdata_q  <= 32'h0;
            rd_q        <= 5'd0;
            incpc_q     <= 32'h0;
            misalign_q  <= 1'b0;
        end else if (MemStall) begin
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            regwrite_q  <= RegWriteM & ~mis;
            resultsrc_q <= ResultSrcM;
            aluout_q    <= ALUoutM;
            readdata_q  <= load_data;
            rd_q        <= RdM;
            incpc_q     <= inc_PCM;
            misalign_q  <= mis;
        end
    end

    assign RegWriteW  = regwrite_q;
    assign ResultSrcW = resultsrc_q;
    assign ALUoutW    = aluout_q;
    assign ReadDataW  = readdata_q;
    assign RdW        = rd_q;
    assign inc_PCW    = incpc_q;
    assign MisalignW  = misalign_q;
    assign BusErr     = buserr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus W-stage scoreboard.
// Latency: n/a (simulation only).
// Backpressure: ack delay per vector drives the stall path.
module tb_mem_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUoutM;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;
    logic [31:0] Rd2M;
    logic [31:0] inc_PCM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        MemStall;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUoutW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] inc_PCW;
    logic        MisalignW;
    logic        BusErr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ALUoutM    (ALUoutM),
        .funct3M    (funct3M),
        .RdM        (RdM),
        .Rd2M       (Rd2M),
        .inc_PCM    (inc_PCM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .MemStall   (MemStall),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUoutW    (ALUoutW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .inc_PCW    (inc_PCW),
        .MisalignW  (MisalignW),
        .BusErr     (BusErr)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rd2;
        logic [31:0] pc;
        int          ack_dly;   // -1: never ack
        logic [31:0] rdata;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_stall;
        logic [31:0] exp_rdw;
        logic        exp_mis;
        logic        exp_buserr;
        logic        exp_rw;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdw;
        logic        chk_rdw;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        mis;
        logic        buserr;
    } w_t;

    w_t   exp_q[$];
    vec_t vecs[14];

    function automatic vec_t mk(
        input logic rw, input logic [1:0] rs, input logic mw, input logic [31:0] alu,
        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] rd2,
        input logic [31:0] pc, input int ack_dly, input logic [31:0] rdata,
        input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
        input int exp_stall, input logic [31:0] exp_rdw, input logic exp_mis,
        input logic exp_buserr, input logic exp_rw);
        vec_t v;
        v.rw = rw; v.rs = rs; v.mw = mw; v.alu = alu; v.f3 = f3; v.rd = rd;
        v.rd2 = rd2; v.pc = pc; v.ack_dly = ack_dly; v.rdata = rdata;
        v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_stall = exp_stall; v.exp_rdw = exp_rdw; v.exp_mis = exp_mis;
        v.exp_buserr = exp_buserr; v.exp_rw = exp_rw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        RegWriteM  = 1'b0;
        ResultSrcM = RES_ALU;
        MemWriteM  = 1'b0;
        ALUoutM    = 32'h0;
        funct3M    = 3'b000;
        RdM        = 5'd0;
        Rd2M       = 32'h0;
        inc_PCM    = 32'h0;
        dmem_rdata = 32'h0;
        dmem_ack   = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        int stalls;
        w_t e;
        w_t g;
        @(negedge clk);
        RegWriteM  = v.rw;
        ResultSrcM = v.rs;
        MemWriteM  = v.mw;
        ALUoutM    = v.alu;
        funct3M    = v.f3;
        RdM        = v.rd;
        Rd2M       = v.rd2;
        inc_PCM    = v.pc;
        dmem_rdata = v.rdata;
        dmem_ack   = (v.ack_dly == 0);
        e.rw = v.exp_rw; e.rs = v.rs; e.alu = v.alu; e.rdw = v.exp_rdw;
        e.chk_rdw = (v.rs == RES_MEM) && !v.exp_mis;
        e.rd = v.rd; e.pc = v.pc; e.mis = v.exp_mis; e.buserr = v.exp_buserr;
        exp_q.push_back(e);
        #1;
        chk($sformatf("v%0d dmem_req", idx), 32'(dmem_req), 32'(v.exp_req));
        if (v.exp_req) begin
            chk($sformatf("v%0d dmem_addr", idx), dmem_addr, v.alu & 32'hFFFF_FFFC);
            chk($sformatf("v%0d dmem_we", idx), 32'(dmem_we), 32'(v.mw));
            if (v.mw) begin
                chk($sformatf("v%0d dmem_be", idx), 32'(dmem_be), 32'(v.exp_be));
                chk($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.exp_wdata);
            end
        end else begin
            chk($sformatf("v%0d dmem_be idle", idx), 32'(dmem_be), 32'h0);
        end
        stalls = 0;
        while (MemStall) begin
            if (stalls >= 40) begin
                checks++;
                errors++;
                $display("FAIL v%0d stall_bound: still stalled after %0d cycles, expected %0d", idx, stalls, v.exp_stall);
                break;
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d bubble RegWriteW", idx), 32'(RegWriteW), 32'h0);
            chk($sformatf("v%0d bubble MisalignW", idx), 32'(MisalignW), 32'h0);
            stalls++;
            @(negedge clk);
            if (v.ack_dly == stalls) dmem_ack = 1'b1;
            #1;
        end
        chk($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(v.exp_stall));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: queue empty, expected one entry", idx);
        end else begin
            e = exp_q.pop_front();
            g.rw = RegWriteW; g.rs = ResultSrcW; g.alu = ALUoutW; g.rdw = ReadDataW;
            g.rd = RdW; g.pc = inc_PCW; g.mis = MisalignW; g.buserr = BusErr;
            chk($sformatf("v%0d RegWriteW", idx), 32'(g.rw), 32'(e.rw));
            chk($sformatf("v%0d ResultSrcW", idx), 32'(g.rs), 32'(e.rs));
            chk($sformatf("v%0d ALUoutW", idx), g.alu, e.alu);
            chk($sformatf("v%0d RdW", idx), 32'(g.rd), 32'(e.rd));
            chk($sformatf("v%0d inc_PCW", idx), g.pc, e.pc);
            chk($sformatf("v%0d MisalignW", idx), 32'(g.mis), 32'(e.mis));
            chk($sformatf("v%0d BusErr", idx), 32'(g.buserr), 32'(e.buserr));
            if (e.chk_rdw) chk($sformatf("v%0d ReadDataW", idx), g.rdw, e.rdw);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'h0);
        chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'h0);
        chk({tag, " ALUoutW"}, ALUoutW, 32'h0);
        chk({tag, " ReadDataW"}, ReadDataW, 32'h0);
        chk({tag, " RdW"}, 32'(RdW), 32'h0);
        chk({tag, " inc_PCW"}, inc_PCW, 32'h0);
        chk({tag, " MisalignW"}, 32'(MisalignW), 32'h0);
        chk({tag, " BusErr"}, 32'(BusErr), 32'h0);
        chk({tag, " dmem_req"}, 32'(dmem_req), 32'h0);
        chk({tag, " MemStall"}, 32'(MemStall), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        //             rw  rs     mw  alu            f3      rd     rd2            pc            ack rdata          req be     wdata          stl rdw            mis berr rwW
        vecs[0]  = mk(1, RES_ALU, 0, 32'h1234_5678, 3'b000, 5'd5,  32'h0,         32'h0000_0104, -1, 32'h0,         0, 4'h0, 32'h0,         0,  32'h0,         0, 0, 1);
        vecs[1]  = mk(0, RES_ALU, 1, 32'h0000_0100, F3_W,   5'd0,  32'hDEAD_BEEF, 32'h0000_0108,  0, 32'h0,         1, 4'hF, 32'hDEAD_BEEF, 0,  32'h0,         0, 0, 0);
        vecs[2]  = mk(1, RES_MEM, 0, 32'h0000_0203, F3_B,   5'd6,  32'h0,         32'h0000_010C,  3, 32'h8000_0000, 1, 4'h0, 32'h0,         3,  32'hFFFF_FF80, 0, 0, 1);
        vecs[3]  = mk(1, RES_MEM, 0, 32'h0000_0203, F3_BU,  5'd7,  32'h0,         32'h0000_0110,  0, 32'h8000_0000, 1, 4'h0, 32'h0,         0,  32'h0000_0080, 0, 0, 1);
        vecs[4]  = mk(0, RES_ALU, 1, 32'h0000_0302, F3_H,   5'd0,  32'h1234_ABCD, 32'h0000_0114,  1, 32'h0,         1, 4'hC, 32'hABCD_ABCD, 1,  32'h0,         0, 0, 0);
        vecs[5]  = mk(1, RES_MEM, 0, 32'h0000_0302, F3_HU,  5'd8,  32'h0,         32'h0000_0118,  0, 32'hBEEF_0000, 1, 4'h0, 32'h0,         0,  32'h0000_BEEF, 0, 0, 1);
        vecs[6]  = mk(1, RES_MEM, 0, 32'h0000_0401, F3_W,   5'd9,  32'h0,         32'h0000_011C, -1, 32'h0,         0, 4'h0, 32'h0,         0,  32'h0,         1, 0, 0);
        vecs[7]  = mk(0, RES_ALU, 1, 32'h0000_0101, F3_B,   5'd0,  32'h0000_00A5, 32'h0000_0120,  0, 32'h0,         1, 4'h2, 32'hA5A5_A5A5, 0,  32'h0,         0, 0, 0);
        vecs[8]  = mk(1, RES_MEM, 0, 32'h0000_0206, F3_H,   5'd10, 32'h0,         32'h0000_0124,  2, 32'h8001_0000, 1, 4'h0, 32'h0,         2,  32'hFFFF_8001, 0, 0, 1);
        vecs[9]  = mk(1, RES_PC4, 0, 32'h0000_0040, 3'b000, 5'd1,  32'h0,         32'h0000_0208, -1, 32'h0,         0, 4'h0, 32'h0,         0,  32'h0,         0, 0, 1);
        vecs[10] = mk(1, RES_MEM, 0, 32'h0000_0500, F3_W,   5'd11, 32'h0,         32'h0000_020C,  0, 32'h1122_3344, 1, 4'h0, 32'h0,         0,  32'h1122_3344, 0, 0, 1);
        vecs[11] = mk(0, RES_ALU, 1, 32'h0000_0303, F3_H,   5'd0,  32'h0000_5555, 32'h0000_0210, -1, 32'h0,         0, 4'h0, 32'h0,         0,  32'h0,         1, 0, 0);
        vecs[12] = mk(1, RES_MEM, 0, 32'h0000_0600, F3_W,   5'd12, 32'h0,         32'h0000_0214, -1, 32'hFFFF_FFFF, 1, 4'h0, 32'h0,         16, 32'h0,         0, 1, 1);
        vecs[13] = mk(1, RES_MEM, 0, 32'h0000_0604, F3_W,   5'd13, 32'h0,         32'h0000_0218,  0, 32'hCAFE_F00D, 1, 4'h0, 32'h0,         0,  32'hCAFE_F00D, 0, 1, 1);

        rst = 1'b1;
        drive_nop();
        #12;
        chk_w_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) apply(i, vecs[i]);

        // Reset while the bus is in its second wait cycle.
        @(negedge clk);
        RegWriteM  = 1'b1;
        ResultSrcM = RES_MEM;
        MemWriteM  = 1'b0;
        ALUoutM    = 32'h0000_0700;
        funct3M    = F3_W;
        RdM        = 5'd14;
        inc_PCM    = 32'h0000_0300;
        dmem_ack   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre-reset MemStall", 32'(MemStall), 32'h1);
        rst = 1'b1;
        #1;
        chk_w_zero("async reset");
        @(negedge clk);
        drive_nop();
        @(negedge clk);
        rst = 1'b0;
        // Zero-wait load right after reset: FSM must be back in IDLE.
        apply(14, mk(1, RES_MEM, 0, 32'h0000_0704, F3_W, 5'd15, 32'h0, 32'h0000_0304,
                     0, 32'h0BAD_F00D, 1, 4'h0, 32'h0, 0, 32'h0BAD_F00D, 0, 0, 1));

        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
